// File: rtl/adc_spi_rx.sv
// Serial receiver for a 16-bit-frame SPI ADC: generates adc_cs/adc_clk and captures a 12-bit sample.
// Define ADC_SPI_RX_AVG4_EN to report the truncated average of every four samples instead of each one.
module adc_spi_rx #(
    parameter int CLK_DIV   = 2,
    parameter int QUIET_CYC = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        adc_sd,
    output logic        adc_clk,
    output logic        adc_cs,
    output logic [11:0] data,
    output logic        ready
);

    typedef enum logic [1:0] {IDLE, CONVERT, QUIET} state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYC - 1);
    localparam logic [5:0] HALF_LAST  = 6'd32;

    state_t      state, state_next;
    logic [7:0]  div_cnt, div_next;
    logic [5:0]  half_cnt, half_next;
    logic [7:0]  quiet_cnt, quiet_next;
    logic [11:0] shift_reg, shift_next;
    logic [11:0] data_next;
    logic        adc_clk_next, adc_cs_next, ready_next;
`ifdef ADC_SPI_RX_AVG4_EN
    logic [13:0] acc, acc_next, acc_sum;
    logic [1:0]  frame_cnt, frame_next;
`endif

    // A frame is 33 half-periods of adc_clk; odd half-periods are the low phase.
    always_comb begin
        state_next   = state;
        div_next     = div_cnt;
        half_next    = half_cnt;
        quiet_next   = quiet_cnt;
        shift_next   = shift_reg;
        data_next    = data;
        adc_clk_next = 1'b1;
        adc_cs_next  = 1'b1;
        ready_next   = 1'b0;
`ifdef ADC_SPI_RX_AVG4_EN
        acc_next     = acc;
        frame_next   = frame_cnt;
        acc_sum      = acc + {2'b00, shift_reg};
`endif
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next  = CONVERT;
                    adc_cs_next = 1'b0;
                    div_next    = 8'd0;
                    half_next   = 6'd0;
                    shift_next  = 12'd0;
                end
            end
            CONVERT: begin
                adc_cs_next  = 1'b0;
                adc_clk_next = adc_clk;
                if (div_cnt == DIV_LAST) begin
                    div_next  = 8'd0;
                    half_next = half_cnt + 6'd1;
                    if (half_cnt == HALF_LAST) begin
                        state_next   = QUIET;
                        adc_cs_next  = 1'b1;
                        adc_clk_next = 1'b1;
                        quiet_next   = 8'd0;
`ifdef ADC_SPI_RX_AVG4_EN
                        if (frame_cnt == 2'd3) begin
                            data_next  = acc_sum[13:2];
                            ready_next = 1'b1;
                            acc_next   = 14'd0;
                            frame_next = 2'd0;
                        end else begin
                            acc_next   = acc_sum;
                            frame_next = frame_cnt + 2'd1;
                        end
`else
                        data_next  = shift_reg;
                        ready_next = 1'b1;
`endif
                    end else begin
                        adc_clk_next = half_cnt[0];
                        // The four leading bits fall off the top of the 12-bit register.
                        if (half_cnt[0])
                            shift_next = {shift_reg[10:0], adc_sd};
                    end
                end else begin
                    div_next = div_cnt + 8'd1;
                end
            end
            QUIET: begin
                if (quiet_cnt == QUIET_LAST) begin
                    if (enable) begin
                        state_next  = CONVERT;
                        adc_cs_next = 1'b0;
                        div_next    = 8'd0;
                        half_next   = 6'd0;
                        shift_next  = 12'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    quiet_next = quiet_cnt + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= 8'd0;
            half_cnt  <= 6'd0;
            quiet_cnt <= 8'd0;
            shift_reg <= 12'd0;
            data      <= 12'd0;
            adc_clk   <= 1'b1;
            adc_cs    <= 1'b1;
            ready     <= 1'b0;
`ifdef ADC_SPI_RX_AVG4_EN
            acc       <= 14'd0;
            frame_cnt <= 2'd0;
`endif
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            half_cnt  <= half_next;
            quiet_cnt <= quiet_next;
            shift_reg <= shift_next;
            data      <= data_next;
            adc_clk   <= adc_clk_next;
            adc_cs    <= adc_cs_next;
            ready     <= ready_next;
`ifdef ADC_SPI_RX_AVG4_EN
            acc       <= acc_next;
            frame_cnt <= frame_next;
`endif
        end
    end

endmodule

// File: tb/tb_adc_spi_rx.sv
// Randomized self-checking bench for adc_spi_rx with a behavioural ADC and frame-level reference model.
// Honours ADC_SPI_RX_AVG4_EN in its reference model when that macro is defined.
module tb_adc_spi_rx;

    localparam int DIV       = 2;
    localparam int QC        = 4;
    localparam int FRAME_LEN = 33 * DIV;
    localparam int PERIOD    = FRAME_LEN + QC;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        adc_sd;
    logic        adc_clk;
    logic        adc_cs;
    logic [11:0] data;
    logic        ready;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int last_start = -1;

    logic [15:0] adc_q[$];
    logic [11:0] hist[$];
    logic [11:0] model_data = 12'd0;
    logic [15:0] frames[$];

    adc_spi_rx #(.CLK_DIV(DIV), .QUIET_CYC(QC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .adc_sd(adc_sd),
        .adc_clk(adc_clk), .adc_cs(adc_cs), .data(data), .ready(ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC: takes the next queued frame at chip-select fall and shifts it out MSB first on adc_clk falls.
    always begin
        logic [15:0] word;
        @(negedge adc_cs);
        word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge adc_clk or posedge adc_cs);
            if (adc_cs) break;
            adc_sd = word[15 - i];
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] frame);
        adc_q.push_back(frame);
    endtask

    task automatic pulseEnable();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Reference model: each completed frame yields its low 12 bits (or the truncated mean of four).
    task automatic modelFrame(input logic [15:0] frame, output logic exp_ready, output logic [11:0] exp_data);
`ifdef ADC_SPI_RX_AVG4_EN
        int sum;
        hist.push_back(frame[11:0]);
        exp_ready = 1'b0;
        if (hist.size() == 4) begin
            sum = 0;
            foreach (hist[i]) sum += int'(hist[i]);
            model_data = 12'(sum / 4);
            hist.delete();
            exp_ready = 1'b1;
        end
`else
        model_data = frame[11:0];
        exp_ready  = 1'b1;
`endif
        exp_data = model_data;
    endtask

    task automatic waitCsLow(output bit ok);
        int waited = 0;
        while (adc_cs !== 1'b0 && waited < 4 * PERIOD) begin
            @(negedge clk);
            waited++;
        end
        ok = (adc_cs === 1'b0);
        checkOutput("cs_fall_seen", {31'd0, ok}, 32'd1);
    endtask

    task automatic measureFrame(input logic [15:0] frame, input int drop_at, input bit chained);
        bit          ok;
        int          wave_err = 0;
        int          rises = 0;
        logic        prev_clk = 1'b1;
        logic        exp_clk;
        logic        exp_ready;
        logic [11:0] exp_data;
        waitCsLow(ok);
        if (!ok) return;
        if (chained && last_start >= 0)
            checkOutput("frame_period", cyc - last_start, PERIOD);
        last_start = cyc;
        for (int t = 0; t < FRAME_LEN; t++) begin
            if (t == drop_at) enable = 1'b0;
            exp_clk = ((t / DIV) % 2 == 0);
            if (adc_clk !== exp_clk || adc_cs !== 1'b0 || ready !== 1'b0) wave_err++;
            if (adc_clk === 1'b1 && prev_clk === 1'b0) rises++;
            prev_clk = adc_clk;
            @(negedge clk);
        end
        modelFrame(frame, exp_ready, exp_data);
        checkOutput("frame_waveform", wave_err, 0);
        checkOutput("adc_clk_rises", rises, 16);
        checkOutput("ready_at_end", {31'd0, ready}, {31'd0, exp_ready});
        checkOutput("cs_at_end", {31'd0, adc_cs}, 32'd1);
        checkOutput("clk_at_end", {31'd0, adc_clk}, 32'd1);
        checkOutput("data", {20'd0, data}, {20'd0, exp_data});
        @(negedge clk);
        checkOutput("ready_width", {31'd0, ready}, 32'd0);
    endtask

    task automatic idleCheck(input int n);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (adc_cs !== 1'b1 || adc_clk !== 1'b1 || ready !== 1'b0) errs++;
            @(negedge clk);
        end
        checkOutput("idle_lines", errs, 0);
    endtask

    initial begin
        bit ok;
        reset_n = 1'b0;
        enable  = 1'b0;
        adc_sd  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_cs", {31'd0, adc_cs}, 32'd1);
        checkOutput("reset_clk", {31'd0, adc_clk}, 32'd1);
        checkOutput("reset_data", {20'd0, data}, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        reset_n = 1'b1;
        idleCheck(10);

        // Back-to-back conversions, directed words first, enable dropped mid-way through the last frame.
        frames.push_back(16'h0AC3);
        frames.push_back(16'h0123);
        frames.push_back(16'h0FFF);
        for (int i = 0; i < 5; i++) frames.push_back(16'($urandom));
        foreach (frames[i]) applyStimulus(frames[i]);
        enable = 1'b1;
        foreach (frames[i])
            measureFrame(frames[i], (i == frames.size() - 1) ? 10 : -1, i > 0);
        idleCheck(3 * PERIOD);

        // Single-cycle enable pulses give exactly one frame each.
        for (int i = 0; i < 4; i++) begin
            logic [15:0] f;
            f = (i == 3) ? 16'h05A5 : 16'($urandom);
            applyStimulus(f);
            pulseEnable();
            measureFrame(f, -1, 1'b0);
            idleCheck(PERIOD);
        end

        // Reset in the middle of a frame discards it.
        applyStimulus(16'h0777);
        pulseEnable();
        waitCsLow(ok);
        repeat (20) @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("abort_data", {20'd0, data}, 32'd0);
        checkOutput("abort_cs", {31'd0, adc_cs}, 32'd1);
        checkOutput("abort_clk", {31'd0, adc_clk}, 32'd1);
        checkOutput("abort_ready", {31'd0, ready}, 32'd0);
        hist.delete();
        model_data = 12'd0;
        last_start = -1;
        repeat (3) @(negedge clk);
        checkOutput("ready_in_reset", {31'd0, ready}, 32'd0);
        reset_n = 1'b1;
        idleCheck(PERIOD);
        applyStimulus(16'h03C3);
        pulseEnable();
        measureFrame(16'h03C3, -1, 1'b0);
        idleCheck(PERIOD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
